silly_func_arbiter: RTL and testbench

SILLY_FUNC_ARBITER -- requirements
Module: silly_func_arbiter

---
 rtl/silly_func_pkg.sv | 18 +
 rtl/silly_func_arbiter_rr.sv | 30 +++
 rtl/silly_func_arbiter.sv | 119 +++++++++++
 tb/tb_silly_func_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/silly_func_pkg.sv
// Shared types and constants for the silly_func_arbiter slice.
// Holds the FSM state encoding and the evaluated function's on-set.
package silly_func_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bit k is the function value for abc == k: on for 000, 100, 101.
  localparam logic [7:0] FUNC_ON_SET = 8'b0011_0001;

  function automatic logic func_y(input logic [2:0] abc);
    return FUNC_ON_SET[abc];
  endfunction

endpackage

// File: rtl/silly_func_arbiter_rr.sv
// Combinational round-robin picker for silly_func_arbiter.
// Returns the first set req bit at or above ptr, wrapping modulo NREQ.
module rr_arbiter
  import silly_func_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] win,
  output logic                    valid
);

  localparam int IW = $clog2(NREQ);

  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!valid && req[i] &&
            int'(ptr) + k == ((i < int'(ptr)) ? i + NREQ : i)) begin
          win   = IW'(i);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/silly_func_arbiter.sv
// Round-robin shared evaluator of y = on-set(abc) over NREQ requesters.
// Define FUNC_STATS_EN to add the saturating hit_cnt port and counter.
module silly_func_arbiter
  import silly_func_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [3*NREQ-1:0]       in_abc,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_y,
  output logic                    busy
`ifdef FUNC_STATS_EN
  ,
  output logic [CNT_W-1:0]        hit_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || CNT_W < 1) begin : g_bad_param
    $error("silly_func_arbiter: bad NREQ or CNT_W");
  end

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_nxt;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic [2:0]      abc_win;
  logic [2:0]      op_q;
  logic [IW-1:0]   id_q;
  logic [NREQ-1:0] gnt_d;
  logic            take;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .win   (win),
    .valid (win_vld)
  );

  assign take = (state_q == IDLE) && win_vld;
  assign busy = (state_q != IDLE);

  assign ptr_nxt = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    abc_win = '0;
    gnt_d   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        abc_win  = in_abc[3*i +: 3];
        gnt_d[i] = take;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = EVAL;
      EVAL:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand is captured at the grant edge so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      op_q      <= '0;
      id_q      <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= 1'b0;
    end else begin
      gnt       <= gnt_d;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= 1'b0;
      if (take) begin
        op_q  <= abc_win;
        id_q  <= win;
        ptr_q <= ptr_nxt;
      end
      if (state_q == EVAL) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_y     <= func_y(op_q);
      end
    end
  end

`ifdef FUNC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hit_cnt <= '0;
    else if (state_q == RESP && rsp_y && hit_cnt != '1)
      hit_cnt <= hit_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_silly_func_arbiter.sv
// Directed self-checking bench for silly_func_arbiter.
// Vector table for the function sweep plus hand sequences for corners.
module tb_silly_func_arbiter;

  localparam int NREQ = 3;
  localparam int IW   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [3*NREQ-1:0] in_abc = '0;
  logic [NREQ-1:0] gnt;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic            rsp_y;
  logic            busy;
`ifdef FUNC_STATS_EN
  logic [1:0]      hit_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  silly_func_arbiter #(
    .NREQ  (NREQ),
    .CNT_W (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_abc    (in_abc),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
`ifdef FUNC_STATS_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  typedef struct {
    int         id;
    logic [2:0] abc;
    logic       y;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    vecs[0]  = '{0, 3'b000, 1'b1};
    vecs[1]  = '{1, 3'b011, 1'b0};
    vecs[2]  = '{1, 3'b000, 1'b1};
    vecs[3]  = '{1, 3'b001, 1'b0};
    vecs[4]  = '{1, 3'b010, 1'b0};
    vecs[5]  = '{1, 3'b100, 1'b1};
    vecs[6]  = '{1, 3'b101, 1'b1};
    vecs[7]  = '{1, 3'b110, 1'b0};
    vecs[8]  = '{1, 3'b111, 1'b0};
    vecs[9]  = '{2, 3'b101, 1'b1};
    vecs[10] = '{2, 3'b110, 1'b0};

    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_id_y", {rsp_id, rsp_y}, 0);
    do_reset();

    // Single-requester transactions across all operand codes.
    foreach (vecs[v]) begin
      in_abc = '0;
      in_abc[3*vecs[v].id +: 3] = vecs[v].abc;
      req = NREQ'(1 << vecs[v].id);
      chk("idle_busy", 32'(busy), 0);
      step();
      chk("vec_gnt", 32'(gnt), 32'(1 << vecs[v].id));
      chk("vec_busy", 32'(busy), 1);
      chk("vec_novalid", 32'(rsp_valid), 0);
      req = '0;
      step();
      chk("vec_gnt_off", 32'(gnt), 0);
      chk("vec_valid", 32'(rsp_valid), 1);
      chk("vec_id", 32'(rsp_id), 32'(vecs[v].id));
      chk("vec_y", 32'(rsp_y), 32'(vecs[v].y));
      step();
      chk("vec_valid_off", 32'(rsp_valid), 0);
      chk("vec_y_off", {rsp_id, rsp_y}, 0);
    end

    // All requesters held: grants rotate 0,1,2 every third cycle.
    do_reset();
    in_abc = '0;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_gnt", 32'(gnt), 32'(1 << (k % 3)));
      step();
      chk("rr_gnt_off", 32'(gnt), 0);
      chk("rr_rsp_id", 32'(rsp_id), 32'(k % 3));
      step();
      chk("rr_idle_gnt", 32'(gnt | {2'b0, rsp_valid}), 0);
    end
    req = '0;
    step();

    // Operand changed during EVAL must not affect the result.
    in_abc = 9'b000_000_100;
    req = 3'b001;
    step();
    chk("latch_gnt", 32'(gnt), 1);
    in_abc = 9'b000_000_111;
    req = '0;
    step();
    chk("latch_valid", 32'(rsp_valid), 1);
    chk("latch_y", 32'(rsp_y), 1);
    step();

    // Reset pulse during EVAL aborts the transaction.
    in_abc = '0;
    req = 3'b010;
    step();
    chk("abort_gnt", 32'(gnt), 2);
    rst_n = 1'b0;
    #1;
    chk("abort_gnt0", 32'(gnt), 0);
    chk("abort_busy0", 32'(busy), 0);
    chk("abort_rsp0", {rsp_valid, rsp_id, rsp_y}, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_no_rsp", {gnt, rsp_valid}, 0);
    end
    req = 3'b111;
    step();
    chk("abort_ptr0", 32'(gnt), 1);
    req = '0;
    step();
    step();

`ifdef FUNC_STATS_EN
    do_reset();
    chk("hit_rst", 32'(hit_cnt), 0);
    in_abc = 9'b000_000_101;
    for (int k = 0; k < 5; k++) begin
      req = 3'b001;
      step();
      req = '0;
      step();
      step();
      chk("hit_cnt", 32'(hit_cnt), (k < 3) ? k + 1 : 3);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
